// File: rtl/mult_arbiter_pkg.sv
// Shared widths, core latency and FSM encoding for the multiplier arbiter slice.
package mult_arbiter_pkg;

    localparam int unsigned OPW      = 12;
    localparam int unsigned PRODW    = 24;
    localparam int unsigned CORE_LAT = 6;

    typedef enum logic [2:0] {
        WAIT_CORE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        RUN       = 3'd3,
        RSP       = 3'd4
    } state_e;

endpackage

// File: rtl/booth_mult.sv
// Radix-4 Booth multiplier, one recoded digit per cycle, CORE_LAT busy cycles.
// No reset: the counter drains from any power-up value, so ready always recovers.
module booth_mult
    import mult_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             start,
    input  logic [OPW-1:0]   multiplicand,
    input  logic [OPW-1:0]   multiplier,
    output logic [PRODW-1:0] prod,
    output logic             ready
);

    localparam int unsigned CW = $clog2(CORE_LAT + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PRODW-1:0] acc_q, acc_d;
    logic [PRODW-1:0] mc_q, mc_d;
    logic [OPW:0]     mr_q, mr_d;
    logic [PRODW-1:0] addend;

    always_comb begin
        ready  = (cnt_q == '0);
        prod   = acc_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        mc_d   = mc_q;
        mr_d   = mr_q;
        addend = '0;

        // Booth digit from the overlapping triplet {b(2k+1), b(2k), b(2k-1)}
        case (mr_q[2:0])
            3'b001, 3'b010: addend = mc_q;
            3'b011:         addend = mc_q << 1;
            3'b100:         addend = -(mc_q << 1);
            3'b101, 3'b110: addend = -mc_q;
            default:        addend = '0;
        endcase

        if (ready) begin
            if (start) begin
                cnt_d = CW'(CORE_LAT);
                acc_d = '0;
                mc_d  = {{(PRODW - OPW){multiplicand[OPW-1]}}, multiplicand};
                mr_d  = {multiplier, 1'b0};
            end
        end else begin
            acc_d = acc_q + addend;
            mc_d  = mc_q << 2;
            mr_d  = {{2{mr_q[OPW]}}, mr_q[OPW:2]};
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
        acc_q <= acc_d;
        mc_q  <= mc_d;
        mr_q  <= mr_d;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier core among NREQ requesters.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [PRODW-1:0]    rsp_prod,
    output logic [CNTW-1:0]     op_count
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [PRODW-1:0] prod_q, prod_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0]   win;
    logic             core_start;
    logic             core_ready;
    logic [PRODW-1:0] core_prod;

    // First valid requester found ascending from ptr, wrapping modulo NREQ
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        int unsigned    idx;
        pick = ptr;
        for (int unsigned k = NREQ; k > 0; k--) begin
            idx = (32'(ptr) + k - 1) % NREQ;
            if (valid[IDW'(idx)]) pick = IDW'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        win        = rr_pick(req_valid, rr_q);

        case (state_q)
            WAIT_CORE: begin
                if (core_ready) state_d = IDLE;
            end
            IDLE: begin
                if (core_ready && |req_valid) begin
                    req_ready[win] = 1'b1;
                    id_d    = win;
                    a_d     = req_a[win*OPW +: OPW];
                    b_d     = req_b[win*OPW +: OPW];
                    rr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                    state_d = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (core_ready) begin
                    prod_d  = core_prod;
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_CORE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_CORE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_id   = id_q;
    assign rsp_prod = prod_q;
    assign op_count = cnt_q;

    booth_mult u_core (
        .clk          (clk),
        .start        (core_start),
        .multiplicand (a_q),
        .multiplier   (b_q),
        .prod         (core_prod),
        .ready        (core_ready)
    );

endmodule
